// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: run/pause state encoding and BCD digit limit.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/stopwatch_if.sv
// Button-pulse and display bundle between the board front end and stopwatch_ctrl.
// The lap signal exists only when LAP_HOLD_EN is defined.
interface stopwatch_if #(
    parameter int N_DIGITS = 4
);
    logic                    start_stop;
    logic                    clear;
`ifdef LAP_HOLD_EN
    logic                    lap;
`endif
    logic [4*N_DIGITS-1:0]   count_bcd;
    logic                    running;
    logic                    overflow;

`ifdef LAP_HOLD_EN
    modport master (output start_stop, clear, lap, input count_bcd, running, overflow);
    modport slave  (input start_stop, clear, lap, output count_bcd, running, overflow);
`else
    modport master (output start_stop, clear, input count_bcd, running, overflow);
    modport slave  (input start_stop, clear, output count_bcd, running, overflow);
`endif

endinterface

// File: rtl/bcd_digit.sv
// One decade (0-9) counter stage; wraps 9->0 when enabled and flags is_nine for the carry chain.
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] q,
    output logic       is_nine
);

    assign is_nine = (q == BCD_MAX);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q <= 4'd0;
        end else if (en) begin
            q <= is_nine ? 4'd0 : q + 4'd1;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Start/stop/clear stopwatch controller: run/pause FSM, tick prescaler and decade digit cascade.
// Optional lap display freeze is built when LAP_HOLD_EN is defined.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int PRESCALE = 50000
) (
    input  logic      clk,
    input  logic      reset,
    stopwatch_if.slave sw
);

    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    state_t                  state, state_nxt;
    logic [PW-1:0]           pre;
    logic                    tick;
    logic [N_DIGITS:0]       chain;
    logic [N_DIGITS-1:0]     nine;
    logic [4*N_DIGITS-1:0]   digits;
    logic                    ovf;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // clear outranks start_stop; start_stop toggles RUN/PAUSE and leaves IDLE
    always_comb begin
        state_nxt = state;
        if (sw.clear) begin
            state_nxt = ST_IDLE;
        end else if (sw.start_stop) begin
            case (state)
                ST_IDLE:  state_nxt = ST_RUN;
                ST_RUN:   state_nxt = ST_PAUSE;
                ST_PAUSE: state_nxt = ST_RUN;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // Prescaler only advances in RUN so a pause keeps the partial tick
    always_ff @(posedge clk) begin
        if (reset || sw.clear) begin
            pre <= '0;
        end else if (state == ST_RUN) begin
            pre <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
        end
    end

    assign tick     = (state == ST_RUN) && (pre == PRE_LAST);
    assign chain[0] = tick;

    for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
        bcd_digit u_digit (
            .clk     (clk),
            .reset   (reset),
            .clr     (sw.clear),
            .en      (chain[k] && !sw.clear),
            .q       (digits[4*k +: 4]),
            .is_nine (nine[k])
        );
        assign chain[k+1] = chain[k] && nine[k];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= 1'b0;
        end else begin
            ovf <= chain[N_DIGITS] && !sw.clear;
        end
    end

    assign sw.running  = (state == ST_RUN);
    assign sw.overflow = ovf;

`ifdef LAP_HOLD_EN
    logic                  frozen;
    logic [4*N_DIGITS-1:0] hold;

    // Snapshot is taken from the live digits on the lap edge; counting continues underneath
    always_ff @(posedge clk) begin
        if (reset || sw.clear) begin
            frozen <= 1'b0;
        end else if (sw.lap && state != ST_IDLE) begin
            frozen <= ~frozen;
            hold   <= digits;
        end
    end

    assign sw.count_bcd = frozen ? hold : digits;
`else
    assign sw.count_bcd = digits;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomized and directed bench for stopwatch_ctrl (N_DIGITS=2, PRESCALE=4) against a decimal-count model.
module tb_stopwatch_ctrl;

    localparam int ND  = 2;
    localparam int PS  = 4;
    localparam int MOD = 100;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    stopwatch_if #(.N_DIGITS(ND)) sw ();

    stopwatch_ctrl #(.N_DIGITS(ND), .PRESCALE(PS)) dut (
        .clk   (clk),
        .reset (reset),
        .sw    (sw)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: mode 0 idle, 1 run, 2 pause; count kept as a plain decimal integer
    int m_mode, m_pre, m_count, m_hold;
    bit m_ovf, m_frozen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r = '0;
        int x = v;
        for (int d = 0; d < ND; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic void model(input bit r, input bit ss, input bit cl, input bit lp);
        bit tick;
        tick = (m_mode == 1) && (m_pre == PS - 1);
        if (r) begin
            m_mode = 0; m_pre = 0; m_count = 0; m_ovf = 0; m_frozen = 0;
        end else if (cl) begin
            m_mode = 0; m_pre = 0; m_count = 0; m_ovf = 0; m_frozen = 0;
        end else begin
`ifdef LAP_HOLD_EN
            if (lp && m_mode != 0) begin
                if (!m_frozen) m_hold = m_count;
                m_frozen = !m_frozen;
            end
`endif
            m_ovf = tick && (m_count == MOD - 1);
            if (tick) m_count = (m_count + 1) % MOD;
            if (m_mode == 1) m_pre = (m_pre + 1) % PS;
            if (ss) m_mode = (m_mode == 1) ? 2 : 1;
        end
    endfunction

    task automatic step(input bit r, input bit ss, input bit cl, input bit lp);
        @(negedge clk);
        reset         = r;
        sw.start_stop = ss;
        sw.clear      = cl;
`ifdef LAP_HOLD_EN
        sw.lap        = lp;
`endif
        model(r, ss, cl, lp);
        @(posedge clk);
        #1;
        check("count_bcd", 32'(sw.count_bcd), m_frozen ? to_bcd(m_hold) : to_bcd(m_count));
        check("running",   32'(sw.running),   32'(m_mode == 1));
        check("overflow",  32'(sw.overflow),  32'(m_ovf));
    endtask

    task automatic run_until_count(input int c, input int pre_val);
        int n = 0;
        while (!(m_count == c && (pre_val < 0 || m_pre == pre_val)) && n < 2000) begin
            step(0, 0, 0, 0);
            n++;
        end
        if (n >= 2000) check("timeout", 32'd0, 32'd1);
    endtask

    int saved;
    int ovf_seen;

    initial begin
        reset = 1'b1; sw.start_stop = 1'b0; sw.clear = 1'b0;
`ifdef LAP_HOLD_EN
        sw.lap = 1'b0;
`endif
        m_mode = 0; m_pre = 0; m_count = 0; m_ovf = 0; m_frozen = 0; m_hold = 0;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("reset_count", 32'(sw.count_bcd), 32'h0);
        check("reset_running", 32'(sw.running), 32'h0);
        check("reset_ovf", 32'(sw.overflow), 32'h0);

        // 1: start then 40 clocks -> ten ticks
        step(0, 1, 0, 0);
        repeat (40) step(0, 0, 0, 0);
        check("t1_count", 32'(sw.count_bcd), 32'h10);
        check("t1_running", 32'(sw.running), 32'h1);

        // 2: wrap from 99
        run_until_count(99, 0);
        ovf_seen = 0;
        repeat (4) begin
            step(0, 0, 0, 0);
            ovf_seen += int'(sw.overflow);
        end
        check("t2_count", 32'(sw.count_bcd), 32'h00);
        check("t2_ovf_now", 32'(sw.overflow), 32'h1);
        step(0, 0, 0, 0);
        ovf_seen += int'(sw.overflow);
        check("t2_ovf_once", 32'(ovf_seen), 32'd1);
        check("t2_running", 32'(sw.running), 32'h1);

        // 3: pause with prescaler at 2, resume; tick lands 2 clocks after resume
        run_until_count(7, 2);
        step(0, 1, 0, 0);
        saved = m_count;
        repeat (20) step(0, 0, 0, 0);
        check("t3_frozen", 32'(sw.count_bcd), to_bcd(saved));
        check("t3_paused", 32'(sw.running), 32'h0);
        step(0, 1, 0, 0);
        check("t3_resume_hold", 32'(sw.count_bcd), to_bcd(saved));
        step(0, 0, 0, 0);
        check("t3_resume_tick", 32'(sw.count_bcd), to_bcd(saved + 1));

        // 4: clear and start_stop together in RUN
        repeat (5) step(0, 0, 0, 0);
        step(0, 1, 1, 0);
        check("t4_count", 32'(sw.count_bcd), 32'h0);
        check("t4_running", 32'(sw.running), 32'h0);
        check("t4_ovf", 32'(sw.overflow), 32'h0);

        // 5: start_stop on the tick cycle at count 05
        step(0, 1, 0, 0);
        run_until_count(5, PS - 1);
        step(0, 1, 0, 0);
        check("t5_count", 32'(sw.count_bcd), 32'h06);
        check("t5_running", 32'(sw.running), 32'h0);

`ifdef LAP_HOLD_EN
        // 6: lap freeze at 23, release at 33
        step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        run_until_count(23, 0);
        step(0, 0, 0, 1);
        repeat (40) step(0, 0, 0, 0);
        check("t6_frozen", 32'(sw.count_bcd), 32'h23);
        step(0, 0, 0, 1);
        check("t6_release", 32'(sw.count_bcd), 32'h33);
`endif

        // Random pulses, including mid-count resets
        step(0, 0, 1, 0);
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 11) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
